cla_serial_word_adder: RTL and testbench

- Sequential wide-word adder. Accepts WIDTH-bit operands over a valid/ready handshake.
- Adds the operands one 4-bit slice per clock, starting at the least significant nibble.
- Each slice uses an internal 4-bit carry-lookahead stage: generate g=a&b, propagate p=a^b, carries c1..c4 in flat lookahead form, sum=p^c.
- Sits upstream of accumulator/ALU logic that needs wide sums without a wide combinational carry chain.

---
 rtl/cla_serial_word_adder.sv | 85 ++++++++
 tb/tb_cla_serial_word_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cla_serial_word_adder.sv
// cla_serial_word_adder: wide adder doing one 4-bit carry-lookahead slice per clock; `define CLA_SERIAL_SUB_EN adds a subtract port
module cla_serial_word_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIB = WIDTH / 4;
    localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_r, b_r;
    logic [CW-1:0] cnt;
    logic c_r, last;
    logic [3:0] an, bn, g, p, s;
    logic [4:0] c;
    assign an = a_r[{cnt, 2'b00} +: 4];
    assign bn = b_r[{cnt, 2'b00} +: 4];
    assign last = cnt == CW'(NIB - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    // flat carry-lookahead for the current nibble
    always_comb begin
        g = an & bn;
        p = an ^ bn;
        c[0] = c_r;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s = p ^ c[3:0];
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // next state: accept, iterate NIB slices, then hold the result until taken
    always_comb begin
        state_n = state == IDLE ? (in_valid ? RUN : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                :                 (out_ready ? IDLE : DONE);
    end
    // operand latch and per-slice accumulation of sum and carry
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            c_r  <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r  <= a;
`ifdef CLA_SERIAL_SUB_EN
            b_r  <= sub ? ~b : b;
            c_r  <= sub ? 1'b1 : cin;
`else
            b_r  <= b;
            c_r  <= cin;
`endif
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == RUN) begin
            sum[{cnt, 2'b00} +: 4] <= s;
            c_r <= c[4];
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) cout <= c[4];
        end
    end
endmodule

// File: tb/tb_cla_serial_word_adder.sv
// tb_cla_serial_word_adder: directed vector table, handshake corner cases and random ops at WIDTH 16 and 4
module tb_cla_serial_word_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0, cout;
    logic [15:0] a = '0, b = '0, sum;
    logic iv4 = 1'b0, ir4, ci4 = 1'b0, ov4, or4 = 1'b0, co4;
    logic [3:0] a4 = '0, b4 = '0, s4;
`ifdef CLA_SERIAL_SUB_EN
    logic sub = 1'b0;
    logic sub4 = 1'b0;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    cla_serial_word_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CLA_SERIAL_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    cla_serial_word_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(ci4),
`ifdef CLA_SERIAL_SUB_EN
        .sub(sub4),
`endif
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] es;
        logic        ec;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                          input logic [15:0] es, input logic ec, input int hold);
        int t = 0;
        int lat = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("in_ready_idle", 32'(in_ready), 1);
        a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        chk("in_ready_run", 32'(in_ready), 0);
        while (!out_valid && lat < 50) begin
            in_valid = 1'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, 4);
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_sum", 32'(sum), 32'(es));
            chk("hold_cout", 32'(cout), 32'(ec));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("in_ready_after_hs", 32'(in_ready), 1);
        chk("out_valid_after_hs", 32'(out_valid), 0);
    endtask

    initial begin
        vec_t vt[8];
        logic [16:0] m;
        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vt[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vt[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
        vt[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vt[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vt[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst4_in_ready", 32'(ir4), 1);
        for (int i = 0; i < 8; i++) run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].es, vt[i].ec, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 3);
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_cout", 32'(cout), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_pulse", 32'(out_valid), 0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0);
`ifdef CLA_SERIAL_SUB_EN
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 0);
        run_op(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 0);
        sub = 1'b0;
`endif
        for (int i = 0; i < 150; i++) begin
            logic [15:0] ra, rb;
            logic rc;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            m = 17'(ra) + 17'(rb) + 17'(rc);
            repeat ($urandom_range(0, 2)) tick();
            run_op(ra, rb, rc, m[15:0], m[16], int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 150; i++) begin
            logic [3:0] ra, rb;
            logic rc;
            logic [4:0] m4;
            int lat;
            ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
            m4 = 5'(ra) + 5'(rb) + 5'(rc);
            repeat ($urandom_range(0, 2)) tick();
            chk("w4_in_ready", 32'(ir4), 1);
            a4 = ra; b4 = rb; ci4 = rc; iv4 = 1'b1;
            tick();
            iv4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
            lat = 0;
            while (!ov4 && lat < 20) begin
                tick();
                lat++;
            end
            iv4 = 1'b0;
            chk("w4_latency", lat, 1);
            chk("w4_result", 32'({co4, s4}), 32'(m4));
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("w4_hold", 32'({ov4, co4, s4}), 32'({1'b1, m4}));
            end
            or4 = 1'b1;
            tick();
            or4 = 1'b0;
            chk("w4_after_hs", 32'({ir4, ov4}), 32'h2);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
